// File: rtl/apb_pwm_ctrl_if.sv
// apb_pwm_ctrl_if: APB3 slave bus bundle for the PWM controller
interface apb_pwm_ctrl_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
   modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_pwm_ctrl.sv
// apb_pwm_ctrl: APB-programmed PWM generator with shadowed period/duty and graceful stop
module apb_pwm_ctrl #(
   parameter int CW = 16
) (
   input  logic           PCLK,
   input  logic           PRESET,
   apb_pwm_ctrl_if.slave  apb,
   output logic           pwm_out,
   output logic           period_tick
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_e;
   state_e state_q, state_d;
   logic en_q, en_d, pol_q, pol_d, pwm_q, pwm_d;
   logic [CW-1:0] period_q, period_d, duty_q, duty_d;
   logic [CW-1:0] per_sh_q, per_sh_d, duty_sh_q, duty_sh_d, cnt_q, cnt_d, cnt_next;
   logic [11:0] addr;
   logic mapped, err, wr_ok, run_nz, period_end, active;
   assign addr = apb.PADDR[11:0];
   assign mapped = (addr == 12'h000) || (addr == 12'h004) || (addr == 12'h008) || (addr == 12'h00C);
   assign err = apb.PSEL & apb.PENABLE & (!mapped | (apb.PWRITE & (addr == 12'h00C)));
   assign wr_ok = apb.PSEL & apb.PENABLE & apb.PWRITE & !err;
   assign apb.PREADY = 1'b1;
   assign apb.PSLVERR = !PRESET & err;
   // A zero period parks the counter: no wrap, no tick, output inactive
   assign run_nz = (state_q != IDLE) && (per_sh_q != '0);
   assign period_end = run_nz && (cnt_q == per_sh_q - CW'(1));
   assign active = run_nz && (cnt_q < duty_sh_q);
   assign period_tick = !PRESET & period_end;
   assign pwm_out = pwm_q;
   assign cnt_next = (!run_nz || period_end) ? '0 : cnt_q + CW'(1);
   always_comb begin
      apb.PRDATA = '0;
      if (apb.PSEL)
         case (addr)
            12'h000: apb.PRDATA = {30'b0, pol_q, en_q};
            12'h004: apb.PRDATA = 32'(period_q);
            12'h008: apb.PRDATA = 32'(duty_q);
            12'h00C: apb.PRDATA = 32'(cnt_q) | {14'b0, state_q, 16'b0};
            default: apb.PRDATA = '0;
         endcase
   end
   always_comb begin
      en_d = (wr_ok && addr == 12'h000) ? apb.PWDATA[0] : en_q;
      pol_d = (wr_ok && addr == 12'h000) ? apb.PWDATA[1] : pol_q;
      period_d = (wr_ok && addr == 12'h004) ? apb.PWDATA[CW-1:0] : period_q;
      duty_d = (wr_ok && addr == 12'h008) ? apb.PWDATA[CW-1:0] : duty_q;
      pwm_d = active ^ pol_q;
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      per_sh_d = per_sh_q;
      duty_sh_d = duty_sh_q;
      case (state_q)
         IDLE: if (en_q) begin
            state_d = RUN;
            per_sh_d = period_q;
            duty_sh_d = duty_q;
            cnt_d = '0;
         end
         RUN: begin
            cnt_d = cnt_next;
            if (period_end) begin
               per_sh_d = period_q;
               duty_sh_d = duty_q;
            end
            if (!en_q) state_d = STOP;
         end
         STOP: if (!run_nz || period_end) begin
            state_d = IDLE;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_next;
            if (en_q) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= IDLE;
         en_q <= 1'b0;
         pol_q <= 1'b0;
         pwm_q <= 1'b0;
         period_q <= '0;
         duty_q <= '0;
         per_sh_q <= '0;
         duty_sh_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         en_q <= en_d;
         pol_q <= pol_d;
         pwm_q <= pwm_d;
         period_q <= period_d;
         duty_q <= duty_d;
         per_sh_q <= per_sh_d;
         duty_sh_q <= duty_sh_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_apb_pwm_ctrl.sv
// tb_apb_pwm_ctrl: randomized and directed checks of apb_pwm_ctrl against a behavioural model
module tb_apb_pwm_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pwm_out, period_tick;
   int checks = 0;
   int fails = 0;
   apb_pwm_ctrl_if bus ();
   apb_pwm_ctrl #(.CW(16)) dut (.PCLK(clk), .PRESET(rst), .apb(bus), .pwm_out(pwm_out), .period_tick(period_tick));
   always #5 clk = ~clk;
   // Reference: state 0 idle, 1 running, 2 stopping; plain integer bookkeeping
   int m_st, m_cnt, m_psh, m_dsh, m_per, m_duty;
   bit m_en, m_pol;
   logic m_pwm;
   always @(posedge clk) begin
      automatic int st = m_st;
      automatic int cnt = m_cnt;
      automatic int psh = m_psh;
      automatic int dsh = m_dsh;
      automatic bit live = m_st != 0 && m_psh != 0;
      automatic bit endp = live && m_cnt == m_psh - 1;
      automatic bit act = live && m_cnt < m_dsh;
      if (rst) begin
         m_st <= 0; m_cnt <= 0; m_psh <= 0; m_dsh <= 0; m_per <= 0; m_duty <= 0;
         m_en <= 0; m_pol <= 0; m_pwm <= 0;
      end else begin
         if (m_st == 0) begin
            if (m_en) begin st = 1; psh = m_per; dsh = m_duty; cnt = 0; end
         end else if (m_st == 1) begin
            cnt = (live && !endp) ? m_cnt + 1 : 0;
            if (endp) begin psh = m_per; dsh = m_duty; end
            if (!m_en) st = 2;
         end else if (!live || endp) begin
            st = 0; cnt = 0;
         end else begin
            cnt = m_cnt + 1;
            if (m_en) st = 1;
         end
         m_pwm <= act ^ m_pol;
         m_st <= st; m_cnt <= cnt; m_psh <= psh; m_dsh <= dsh;
         if (bus.PSEL && bus.PENABLE && bus.PWRITE)
            case (bus.PADDR[11:0])
               12'h000: begin m_en <= bus.PWDATA[0]; m_pol <= bus.PWDATA[1]; end
               12'h004: m_per <= int'(bus.PWDATA[15:0]);
               12'h008: m_duty <= int'(bus.PWDATA[15:0]);
               default: ;
            endcase
      end
   end
   function automatic logic exp_tick();
      return !rst && m_st != 0 && m_psh != 0 && m_cnt == m_psh - 1;
   endfunction
   function automatic logic [31:0] exp_status();
      return 32'(m_cnt) | (32'(m_st) << 16);
   endfunction
   function automatic void bus_idle();
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'hC; bus.PWDATA = '0;
   endfunction
   task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic err);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
      @(negedge clk);
      bus.PENABLE = 1'b1;
      #1 err = bus.PSLVERR;
      @(negedge clk);
      bus_idle();
   endtask
   task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic err);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
      @(negedge clk);
      bus.PENABLE = 1'b1;
      #1 d = bus.PRDATA; err = bus.PSLVERR;
      @(negedge clk);
      bus_idle();
   endtask
   task automatic wait_run_cnt(input int k);
      checks++;
      for (int i = 0; i < 300; i++) begin
         if (m_st != 0 && m_cnt == k) return;
         @(negedge clk);
      end
      fails++;
      $display("FAIL wait_cnt: counter never reached %0d (at %0d)", k, m_cnt);
   endtask
   task automatic wait_idle();
      checks++;
      for (int i = 0; i < 300; i++) begin
         if (m_st == 0) return;
         @(negedge clk);
      end
      fails++;
      $display("FAIL wait_idle: state stuck at %0d", m_st);
   endtask
   task automatic test_reset();
      bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 32'h10; bus.PWDATA = 32'h5;
      @(negedge clk);
      #1 checks += 4;
      if (bus.PSLVERR !== 1'b0) begin fails++; $display("FAIL reset_pslverr: got %b want 0", bus.PSLVERR); end
      if (period_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", period_tick); end
      if (pwm_out !== 1'b0) begin fails++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
      if (bus.PREADY !== 1'b1) begin fails++; $display("FAIL pready: got %b want 1", bus.PREADY); end
      bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      for (int a = 0; a < 16; a += 4) begin
         bus.PADDR = 32'(a);
         #1 checks++;
         if (bus.PRDATA !== 32'h0) begin fails++; $display("FAIL reset_reg%0h: got %h want 0", a, bus.PRDATA); end
      end
      rst = 1'b0;
      bus_idle();
   endtask
   task automatic test_basic();
      logic e;
      int highs = 0, ticks = 0;
      apb_wr(32'h4, 32'd10, e);
      apb_wr(32'h8, 32'd3, e);
      apb_wr(32'h0, 32'd1, e);
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         #1 checks += 3;
         if (pwm_out !== m_pwm) begin fails++; $display("FAIL basic_pwm: got %b want %b", pwm_out, m_pwm); end
         if (period_tick !== exp_tick()) begin fails++; $display("FAIL basic_tick: got %b want %b", period_tick, exp_tick()); end
         if (bus.PRDATA !== exp_status()) begin fails++; $display("FAIL basic_status: got %h want %h", bus.PRDATA, exp_status()); end
         if (period_tick) begin
            checks++;
            if (bus.PRDATA[15:0] !== 16'd9) begin fails++; $display("FAIL tick_cnt: got %0d want 9", bus.PRDATA[15:0]); end
         end
         if (i >= 15) begin highs += int'(pwm_out); ticks += int'(period_tick); end
      end
      checks += 2;
      if (highs != 9) begin fails++; $display("FAIL basic_highs: got %0d want 9", highs); end
      if (ticks != 3) begin fails++; $display("FAIL basic_ticks: got %0d want 3", ticks); end
   endtask
   task automatic test_duty_change();
      logic e;
      int highs = 0;
      wait_run_cnt(3);
      apb_wr(32'h8, 32'd7, e);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1 checks += 2;
         if (pwm_out !== m_pwm) begin fails++; $display("FAIL duty_pwm: got %b want %b", pwm_out, m_pwm); end
         if (period_tick !== exp_tick()) begin fails++; $display("FAIL duty_tick: got %b want %b", period_tick, exp_tick()); end
         highs += int'(pwm_out);
      end
      checks++;
      if (highs != 19) begin fails++; $display("FAIL duty_highs: got %0d want 19", highs); end
   endtask
   task automatic test_stop();
      logic e;
      int stops = 0, idles = 0;
      wait_run_cnt(1);
      apb_wr(32'h0, 32'd0, e);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         #1 checks += 2;
         if (bus.PRDATA !== exp_status()) begin fails++; $display("FAIL stop_status: got %h want %h", bus.PRDATA, exp_status()); end
         if (pwm_out !== m_pwm) begin fails++; $display("FAIL stop_pwm: got %b want %b", pwm_out, m_pwm); end
         stops += int'(bus.PRDATA[17:16] == 2'd2);
      end
      checks += 3;
      if (stops != 6) begin fails++; $display("FAIL stop_len: got %0d want 6", stops); end
      if (bus.PRDATA !== 32'h0) begin fails++; $display("FAIL stop_idle: got %h want 0", bus.PRDATA); end
      if (pwm_out !== 1'b0) begin fails++; $display("FAIL stop_out: got %b want 0", pwm_out); end
      apb_wr(32'h0, 32'd1, e);
      wait_run_cnt(1);
      apb_wr(32'h0, 32'd0, e);
      wait_run_cnt(4);
      apb_wr(32'h0, 32'd1, e);
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         #1 checks++;
         if (bus.PRDATA !== exp_status()) begin fails++; $display("FAIL resume_status: got %h want %h", bus.PRDATA, exp_status()); end
         idles += int'(bus.PRDATA[17:16] == 2'd0);
      end
      checks++;
      if (idles != 0) begin fails++; $display("FAIL resume_idle: got %0d idle cycles want 0", idles); end
   endtask
   task automatic test_pol();
      logic e;
      int bad = 0;
      apb_wr(32'h0, 32'd0, e);
      wait_idle();
      apb_wr(32'h4, 32'd4, e);
      apb_wr(32'h8, 32'd4, e);
      apb_wr(32'h0, 32'd3, e);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1 checks++;
         if (pwm_out !== m_pwm) begin fails++; $display("FAIL pol_pwm: got %b want %b", pwm_out, m_pwm); end
         if (i >= 4) bad += int'(pwm_out !== 1'b0);
      end
      apb_wr(32'h0, 32'd2, e);
      repeat (12) @(negedge clk);
      #1 checks += 2;
      if (bad != 0) begin fails++; $display("FAIL pol_full: got %0d high cycles want 0", bad); end
      if (pwm_out !== 1'b1) begin fails++; $display("FAIL pol_idle: got %b want 1", pwm_out); end
      bad = 0;
      apb_wr(32'h8, 32'd0, e);
      apb_wr(32'h0, 32'd3, e);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1 bad += int'(pwm_out !== 1'b1);
      end
      checks++;
      if (bad != 0) begin fails++; $display("FAIL pol_zero: got %0d low cycles want 0", bad); end
   endtask
   task automatic test_zero_and_err();
      logic e;
      logic [31:0] d;
      apb_wr(32'h0, 32'd0, e);
      wait_idle();
      apb_wr(32'h4, 32'd0, e);
      apb_wr(32'h0, 32'd1, e);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1 checks += 3;
         if (period_tick !== 1'b0) begin fails++; $display("FAIL zero_tick: got %b want 0", period_tick); end
         if (bus.PRDATA[15:0] !== 16'h0) begin fails++; $display("FAIL zero_cnt: got %0d want 0", bus.PRDATA[15:0]); end
         if (pwm_out !== 1'b0) begin fails++; $display("FAIL zero_pwm: got %b want 0", pwm_out); end
      end
      apb_wr(32'h10, 32'hFFFF, e);
      checks++;
      if (e !== 1'b1) begin fails++; $display("FAIL err_unmapped: got %b want 1", e); end
      apb_wr(32'hC, 32'h5, e);
      checks++;
      if (e !== 1'b1) begin fails++; $display("FAIL err_status_wr: got %b want 1", e); end
      apb_rd(32'h0, d, e);
      checks++;
      if (d !== 32'h1) begin fails++; $display("FAIL err_ctrl: got %h want 1", d); end
      apb_rd(32'h4, d, e);
      checks++;
      if (d !== 32'h0) begin fails++; $display("FAIL err_period: got %h want 0", d); end
      apb_rd(32'h14, d, e);
      checks += 2;
      if (e !== 1'b1) begin fails++; $display("FAIL rd_unmapped_err: got %b want 1", e); end
      if (d !== 32'h0) begin fails++; $display("FAIL rd_unmapped_data: got %h want 0", d); end
      apb_wr(32'hABC0_0008, 32'h0001_0002, e);
      apb_rd(32'h8, d, e);
      checks++;
      if (d !== 32'h2) begin fails++; $display("FAIL hi_addr_duty: got %h want 2", d); end
   endtask
   task automatic test_reset_mid();
      logic e;
      apb_wr(32'h0, 32'd0, e);
      wait_idle();
      apb_wr(32'h4, 32'd10, e);
      apb_wr(32'h8, 32'd3, e);
      apb_wr(32'h0, 32'd1, e);
      wait_run_cnt(5);
      rst = 1'b1;
      @(negedge clk);
      #1 checks += 2;
      if (pwm_out !== 1'b0) begin fails++; $display("FAIL rmid_pwm: got %b want 0", pwm_out); end
      if (period_tick !== 1'b0) begin fails++; $display("FAIL rmid_tick: got %b want 0", period_tick); end
      for (int a = 0; a < 16; a += 4) begin
         bus.PADDR = 32'(a);
         #1 checks++;
         if (bus.PRDATA !== 32'h0) begin fails++; $display("FAIL rmid_reg%0h: got %h want 0", a, bus.PRDATA); end
      end
      rst = 1'b0;
      bus_idle();
   endtask
   task automatic test_random();
      logic e;
      logic [31:0] a;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) < 2) begin
            case ($urandom_range(0, 4))
               0: a = 32'h0;
               1: a = 32'h4;
               2: a = 32'h8;
               3: a = 32'hC;
               default: a = 32'h10;
            endcase
            apb_wr(a, (a == 32'h0) ? $urandom_range(0, 3) : ($urandom & 32'hFFFF_0000) | $urandom_range(0, 12), e);
            checks++;
            if (e !== (a == 32'hC || a == 32'h10)) begin fails++; $display("FAIL rnd_err: addr %h got %b", a, e); end
         end else begin
            @(negedge clk);
            #1 checks += 3;
            if (pwm_out !== m_pwm) begin fails++; $display("FAIL rnd_pwm: got %b want %b", pwm_out, m_pwm); end
            if (period_tick !== exp_tick()) begin fails++; $display("FAIL rnd_tick: got %b want %b", period_tick, exp_tick()); end
            if (bus.PRDATA !== exp_status()) begin fails++; $display("FAIL rnd_status: got %h want %h", bus.PRDATA, exp_status()); end
         end
      end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_duty_change();
      test_stop();
      test_pol();
      test_zero_and_err();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
